// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared state/op encodings and width constants for the HI/LO multiply/divide sequencer.
package hilo_muldiv_seq_pkg;

  localparam int WIDTH_DEFAULT = 32;

  function automatic int cntBits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cntBits(WIDTH_DEFAULT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MULT    = 3'd1,
    DIV     = 3'd2,
    DIV_FIX = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

endpackage

// File: rtl/hilo_muldiv_seq_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of the whole {A,Q,q-1} accumulator.
module hilo_muldiv_seq_booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   accA_i,
  input  logic [WIDTH-1:0] accQ_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH:0]   accA_o,
  output logic [WIDTH-1:0] accQ_o,
  output logic             qm1_o
);

  logic [WIDTH:0] mExt;
  logic [WIDTH:0] sum;

  // A carries one guard bit so that subtracting M = -2^(W-1) cannot overflow.
  always_comb begin
    mExt = {m_i[WIDTH-1], m_i};
    sum  = accA_i;
    case ({accQ_i[0], qm1_i})
      2'b01:   sum = accA_i + mExt;
      2'b10:   sum = accA_i - mExt;
      default: sum = accA_i;
    endcase
    accA_o = {sum[WIDTH], sum[WIDTH:1]};
    accQ_o = {sum[0], accQ_i[WIDTH-1:1]};
    qm1_o  = accQ_i[0];
  end

endmodule

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle signed multiply (Booth) / divide (restoring) sequencer for HI/LO.
// Done, busy and div_zero are registered off the FSM state, so they trail DONE by one edge.
module hilo_muldiv_seq
  import hilo_muldiv_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             mult_start_i,
  input  logic             div_start_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             mult_done_o,
  output logic             div_done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CntW = cntBits(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   accA_q, accA_d;
  logic [WIDTH-1:0] accQ_q, accQ_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] opM_q, opM_d;
  logic             negQuo_q, negQuo_d;
  logic             negRem_q, negRem_d;
  logic             zeroDiv_q, zeroDiv_d;
  logic             busy_q, busy_d;
  logic             multDone_q, multDone_d;
  logic             divDone_q, divDone_d;
  logic             divZero_q, divZero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   boothA;
  logic [WIDTH-1:0] boothQ;
  logic             boothQm1;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   divShift;
  logic [WIDTH+1:0] divDiff;
  logic [WIDTH:0]   divA;
  logic [WIDTH-1:0] divQ;

  hilo_muldiv_seq_booth_step #(
    .WIDTH(WIDTH)
  ) uBoothStep (
    .accA_i (accA_q),
    .accQ_i (accQ_q),
    .qm1_i  (qm1_q),
    .m_i    (opM_q),
    .accA_o (boothA),
    .accQ_o (boothQ),
    .qm1_o  (boothQm1)
  );

  // Division reuses the accumulator: accA holds the partial remainder, accQ
  // shifts the dividend magnitude out and the quotient bits in.
  always_comb begin
    absA     = op_a_i[WIDTH-1] ? -op_a_i : op_a_i;
    absB     = op_b_i[WIDTH-1] ? -op_b_i : op_b_i;
    divShift = {accA_q[WIDTH-1:0], accQ_q[WIDTH-1]};
    divDiff  = {1'b0, divShift} - {2'b00, opM_q};
    divA     = divDiff[WIDTH+1] ? {1'b0, divShift[WIDTH-1:0]} : divDiff[WIDTH:0];
    divQ     = {accQ_q[WIDTH-2:0], ~divDiff[WIDTH+1]};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    accA_d    = accA_q;
    accQ_d    = accQ_q;
    qm1_d     = qm1_q;
    opM_d     = opM_q;
    negQuo_d  = negQuo_q;
    negRem_d  = negRem_q;
    zeroDiv_d = zeroDiv_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (mult_start_i) begin
          state_d   = MULT;
          op_d      = OP_MULT;
          cnt_d     = CntLast;
          accA_d    = '0;
          accQ_d    = op_a_i;
          qm1_d     = 1'b0;
          opM_d     = op_b_i;
          zeroDiv_d = 1'b0;
          divZero_d = 1'b0;
        end else if (div_start_i) begin
          op_d      = OP_DIV;
          cnt_d     = CntLast;
          accA_d    = '0;
          accQ_d    = absA;
          qm1_d     = 1'b0;
          opM_d     = absB;
          negQuo_d  = op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1];
          negRem_d  = op_a_i[WIDTH-1];
          divZero_d = 1'b0;
          // A zero divisor skips the iterations and reports a cleared result.
          if (op_b_i == '0) begin
            state_d   = DONE;
            zeroDiv_d = 1'b1;
            hi_d      = '0;
            lo_d      = '0;
          end else begin
            state_d   = DIV;
            zeroDiv_d = 1'b0;
          end
        end
      end
      MULT: begin
        accA_d = boothA;
        accQ_d = boothQ;
        qm1_d  = boothQm1;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
          hi_d    = boothA[WIDTH-1:0];
          lo_d    = boothQ;
        end
      end
      DIV: begin
        accA_d = divA;
        accQ_d = divQ;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == '0) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        state_d = DONE;
        lo_d    = negQuo_q ? -accQ_q : accQ_q;
        hi_d    = negRem_q ? -accA_q[WIDTH-1:0] : accA_q[WIDTH-1:0];
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    multDone_d = (state_q == DONE) && (op_q == OP_MULT);
    divDone_d  = (state_q == DONE) && (op_q == OP_DIV);
    if (divDone_d) begin
      divZero_d = zeroDiv_q;
    end
    busy_d = (state_d != IDLE) || (state_q == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= OP_MULT;
      cnt_q      <= '0;
      accA_q     <= '0;
      accQ_q     <= '0;
      qm1_q      <= 1'b0;
      opM_q      <= '0;
      negQuo_q   <= 1'b0;
      negRem_q   <= 1'b0;
      zeroDiv_q  <= 1'b0;
      busy_q     <= 1'b0;
      multDone_q <= 1'b0;
      divDone_q  <= 1'b0;
      divZero_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      accA_q     <= accA_d;
      accQ_q     <= accQ_d;
      qm1_q      <= qm1_d;
      opM_q      <= opM_d;
      negQuo_q   <= negQuo_d;
      negRem_q   <= negRem_d;
      zeroDiv_q  <= zeroDiv_d;
      busy_q     <= busy_d;
      multDone_q <= multDone_d;
      divDone_q  <= divDone_d;
      divZero_q  <= divZero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy_o      = busy_q;
  assign mult_done_o = multDone_q;
  assign div_done_o  = divDone_q;
  assign div_zero_o  = divZero_q;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq: directed cases plus randomized
// operations compared against plain signed arithmetic.
module tb_hilo_muldiv_seq;

   localparam int WIDTH = 32;

   logic             clk_i = 1'b0;
   logic             rst_ni = 1'b0;
   logic             mult_start_i = 1'b0;
   logic             div_start_i = 1'b0;
   logic [WIDTH-1:0] op_a_i = '0;
   logic [WIDTH-1:0] op_b_i = '0;
   logic             busy_o;
   logic             mult_done_o;
   logic             div_done_o;
   logic             div_zero_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   int checkCount = 0;
   int errorCount = 0;

   // Result the model believes HI/LO should be holding between operations.
   logic [WIDTH-1:0] heldHi = '0;
   logic [WIDTH-1:0] heldLo = '0;

   hilo_muldiv_seq #(
      .WIDTH(WIDTH)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .mult_start_i (mult_start_i),
      .div_start_i  (div_start_i),
      .op_a_i       (op_a_i),
      .op_b_i       (op_b_i),
      .busy_o       (busy_o),
      .mult_done_o  (mult_done_o),
      .div_done_o   (div_done_o),
      .div_zero_o   (div_zero_o),
      .hi_o         (hi_o),
      .lo_o         (lo_o)
   );

   // Free-running 10 ns clock.
   always #5 clk_i = ~clk_i;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Behavioural reference: signed 64-bit product, or C-style truncating
   // division with the zero-divisor and most-negative/-1 special cases.
   task automatic refModel(input bit isMult, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo,
                           output bit zero, output int latency);
      longint prod;
      int sa;
      int sb;
      int q;
      int r;
      sa = $signed(a);
      sb = $signed(b);
      zero = 1'b0;
      if (isMult) begin
         prod = longint'(sa) * longint'(sb);
         hi = prod[63:32];
         lo = prod[31:0];
         latency = WIDTH + 1;
      end else if (b == 32'h0) begin
         hi = 32'h0;
         lo = 32'h0;
         zero = 1'b1;
         latency = 1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         hi = 32'h0;
         lo = 32'h8000_0000;
         latency = WIDTH + 2;
      end else begin
         q = sa / sb;
         r = sa % sb;
         hi = r;
         lo = q;
         latency = WIDTH + 2;
      end
   endtask

   // Issues one operation from a post-edge point, follows it to its done
   // pulse and checks latency, busy, result hold, result and pulse width.
   task automatic applyStimulus(input string tag, input bit isMult, input logic [31:0] a,
                                input logic [31:0] b, input bit bothStart, input bit repulse);
      logic [31:0] expHi;
      logic [31:0] expLo;
      bit          expZero;
      int          latency;
      int          n;
      bit          doneSeen;
      bit          busyOk;
      bit          holdOk;
      refModel(isMult, a, b, expHi, expLo, expZero, latency);
      mult_start_i = isMult | bothStart;
      div_start_i  = !isMult | bothStart;
      op_a_i = a;
      op_b_i = b;
      @(posedge clk_i); #1;
      mult_start_i = 1'b0;
      div_start_i  = 1'b0;
      op_a_i = $urandom;
      op_b_i = $urandom;
      checkOutput({tag, ":zeroClr"}, {63'h0, div_zero_o}, 64'h0);
      busyOk   = (busy_o === 1'b1);
      holdOk   = 1'b1;
      doneSeen = 1'b0;
      n = 0;
      while (!doneSeen && n < 60) begin
         if (n < latency - 1 && (hi_o !== heldHi || lo_o !== heldLo)) holdOk = 1'b0;
         if (repulse && n == 10) begin
            mult_start_i = 1'b1;
            op_a_i = 32'h0000_1234;
            op_b_i = 32'h0000_5678;
         end
         if (repulse && n == 11) mult_start_i = 1'b0;
         @(posedge clk_i); #1;
         n++;
         if (mult_done_o === 1'b1 || div_done_o === 1'b1) doneSeen = 1'b1;
         else if (busy_o !== 1'b1) busyOk = 1'b0;
      end
      checkOutput({tag, ":latency"}, 64'(n), 64'(latency));
      checkOutput({tag, ":doneKind"}, {62'h0, mult_done_o, div_done_o}, {62'h0, isMult, !isMult});
      checkOutput({tag, ":hi"}, {32'h0, hi_o}, {32'h0, expHi});
      checkOutput({tag, ":lo"}, {32'h0, lo_o}, {32'h0, expLo});
      checkOutput({tag, ":divZero"}, {63'h0, div_zero_o}, {63'h0, expZero});
      checkOutput({tag, ":busyDone"}, {63'h0, busy_o}, 64'h1);
      checkOutput({tag, ":busyHeld"}, {63'h0, busyOk}, 64'h1);
      checkOutput({tag, ":hiloHold"}, {63'h0, holdOk}, 64'h1);
      @(posedge clk_i); #1;
      checkOutput({tag, ":pulseWidth"}, {62'h0, mult_done_o, div_done_o}, 64'h0);
      checkOutput({tag, ":busyDrop"}, {63'h0, busy_o}, 64'h0);
      checkOutput({tag, ":zeroHeld"}, {63'h0, div_zero_o}, {63'h0, expZero});
      checkOutput({tag, ":hiloAfter"}, {hi_o, lo_o}, {expHi, expLo});
      heldHi = expHi;
      heldLo = expLo;
   endtask

   // Draws an operand biased toward the interesting corners.
   function automatic logic [31:0] pickOperand();
      logic [31:0] v;
      case ($urandom_range(0, 5))
         0: v = 32'h8000_0000;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h0;
         3: begin
            v = 32'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) v = -v;
         end
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Main sequence: reset, directed cases, mid-operation reset, random ops.
   initial begin
      int extraDone;
      bit busySeen;
      #2;
      checkOutput("reset:busy", {63'h0, busy_o}, 64'h0);
      checkOutput("reset:done", {62'h0, mult_done_o, div_done_o}, 64'h0);
      checkOutput("reset:zero", {63'h0, div_zero_o}, 64'h0);
      checkOutput("reset:hilo", {hi_o, lo_o}, 64'h0);
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(posedge clk_i); #1;

      applyStimulus("t1:mul7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
      applyStimulus("t2:mulMinMin", 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
      applyStimulus("t2:mulM1M1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      applyStimulus("t3:divm7d2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      applyStimulus("t3:div7dm2", 1'b0, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
      applyStimulus("t3:divOvf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      applyStimulus("t4:div5d0", 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
      applyStimulus("t4:div9d3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
      applyStimulus("t5:both", 1'b1, 32'd6, 32'd11, 1'b1, 1'b1);

      extraDone = 0;
      busySeen = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (mult_done_o === 1'b1 || div_done_o === 1'b1) extraDone++;
         if (busy_o !== 1'b0) busySeen = 1'b1;
      end
      checkOutput("t5:noExtraDone", 64'(extraDone), 64'h0);
      checkOutput("t5:staysIdle", {63'h0, busySeen}, 64'h0);

      // Abort a division partway through with an asynchronous reset.
      div_start_i = 1'b1;
      op_a_i = 32'd100;
      op_b_i = 32'd7;
      @(posedge clk_i); #1;
      div_start_i = 1'b0;
      repeat (10) @(posedge clk_i);
      #1 rst_ni = 1'b0;
      #1;
      checkOutput("t6:rstBusy", {63'h0, busy_o}, 64'h0);
      checkOutput("t6:rstHilo", {hi_o, lo_o}, 64'h0);
      checkOutput("t6:rstDone", {62'h0, mult_done_o, div_done_o}, 64'h0);
      heldHi = '0;
      heldLo = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      extraDone = 0;
      busySeen = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (mult_done_o === 1'b1 || div_done_o === 1'b1) extraDone++;
         if (busy_o !== 1'b0) busySeen = 1'b1;
      end
      checkOutput("t6:noDone", 64'(extraDone), 64'h0);
      checkOutput("t6:idle", {63'h0, busySeen}, 64'h0);
      applyStimulus("t6:mul3x4", 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);

      for (int i = 0; i < 24; i++) begin
         bit isMult;
         isMult = ($urandom_range(0, 1) == 1);
         applyStimulus($sformatf("rnd%0d", i), isMult, pickOperand(), pickOperand(), 1'b0, 1'b0);
         repeat ($urandom_range(0, 2)) @(posedge clk_i);
         if (!$urandom_range(0, 1)) begin
            #0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
